// File: rtl/instr_encode_loader.sv
// instr_encode_loader: encodes MIPS instruction requests and streams them through a FIFO into instruction memory
module instr_encode_loader #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int MAX_WORDS = 256,
  parameter int CNT_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [2:0]        op_kind_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  input  logic              imem_ready_i,
  output logic [CNT_W-1:0]  wr_count_o,
  output logic              done_o
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {LOAD, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] occ;
  logic [CNT_W-1:0] acc_cnt, wr_cnt, acc_n, wr_n;
  logic [31:0] enc_word;
  logic clr, full, empty, push, pop;
  assign clr = rst_i | flush_i;
  assign full = occ == (PW+1)'(DEPTH);
  assign empty = occ == '0;
  assign op_ready_o = !full && acc_cnt < CNT_W'(MAX_WORDS) && !clr;
  assign imem_we_o = !empty && !clr;
  assign push = op_valid_i && op_ready_o;
  assign pop = imem_we_o && imem_ready_i;
  assign imem_data_o = empty ? '0 : mem[rptr];
  assign imem_addr_o = BASE_ADDR + (ADDR_W'(wr_cnt) << 2);
  assign wr_count_o = wr_cnt;
  assign done_o = state == DONE;
  assign acc_n = acc_cnt + CNT_W'(push);
  assign wr_n = wr_cnt + CNT_W'(pop);
  always_comb begin
    enc_word = {6'h02, rs_i, 21'b0};
    case (op_kind_i)
      3'd0: enc_word = {6'h00, rs_i, rt_i, rd_i, 5'b0, funct_i};
      3'd1: enc_word = {6'h23, rs_i, rt_i, imm_i};
      3'd2: enc_word = {6'h2B, rs_i, rt_i, imm_i};
      3'd3: enc_word = {6'h04, rs_i, rt_i, imm_i};
      3'd4: enc_word = {6'h08, rs_i, rt_i, imm_i};
      3'd5: enc_word = {6'h0A, rs_i, rt_i, imm_i};
      3'd6: enc_word = {6'h03, target_i};
      default: enc_word = {6'h02, rs_i, 21'b0};
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      LOAD: state_n = wr_n == CNT_W'(MAX_WORDS) ? DONE : acc_n == CNT_W'(MAX_WORDS) ? DRAIN : LOAD;
      DRAIN: state_n = wr_n == CNT_W'(MAX_WORDS) ? DONE : DRAIN;
      default: state_n = DONE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (clr) begin
      state <= LOAD;
      wptr <= '0;
      rptr <= '0;
      occ <= '0;
      acc_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      state <= state_n;
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(pop);
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
      acc_cnt <= acc_n;
      wr_cnt <= wr_n;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= enc_word;
  end
endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: directed and random checks of instr_encode_loader against a queue-based reference
module tb_instr_encode_loader;
  localparam int DEPTH = 4;
  localparam int MAXW = 8;
  localparam int CW = 4;
  localparam logic [31:0] BASE = 32'h40;
  logic clk_i = 0, rst_i = 1, flush_i = 0, op_valid_i = 0, imem_ready_i = 0;
  logic [2:0] op_kind_i = 0;
  logic [4:0] rs_i = 0, rt_i = 0, rd_i = 0;
  logic [5:0] funct_i = 0;
  logic [15:0] imm_i = 0;
  logic [25:0] target_i = 0;
  logic op_ready_o, imem_we_o, done_o;
  logic [31:0] imem_addr_o, imem_data_o;
  logic [CW-1:0] wr_count_o;
  int n_cmp = 0, n_err = 0;
  logic [31:0] q[$];
  int m_acc = 0, m_wr = 0;
  int unsigned opc_tab[8] = '{32'h00, 32'h23, 32'h2B, 32'h04, 32'h08, 32'h0A, 32'h03, 32'h02};
  logic [31:0] golden[5] = '{32'h20220005, 32'h8C220004, 32'h00221820, 32'h1022FFFF, 32'h0C000010};
  instr_encode_loader #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_kind_i(op_kind_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .funct_i(funct_i), .imm_i(imm_i),
    .target_i(target_i), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
    .imem_ready_i(imem_ready_i), .wr_count_o(wr_count_o), .done_o(done_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [31:0] ref_enc(input int unsigned k, rs, rt, rd, fn, imm, tg);
    int unsigned w;
    w = opc_tab[k] * 32'h0400_0000;
    if (k == 0) w = w + rs * 32'h20_0000 + rt * 32'h1_0000 + rd * 32'h800 + fn;
    else if (k <= 5) w = w + rs * 32'h20_0000 + rt * 32'h1_0000 + imm;
    else if (k == 6) w = w + tg;
    else w = w + rs * 32'h20_0000;
    return w;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask
  task automatic step();
    bit m_rdy, m_we, push, pop, clr;
    logic [31:0] w;
    #1;
    clr = rst_i || flush_i;
    m_rdy = q.size() < DEPTH && m_acc < MAXW && !clr;
    m_we = q.size() > 0 && !clr;
    chk("op_ready", 32'(op_ready_o), 32'(m_rdy));
    chk("imem_we", 32'(imem_we_o), 32'(m_we));
    chk("imem_data", imem_data_o, q.size() > 0 ? q[0] : 32'h0);
    chk("imem_addr", imem_addr_o, BASE + 32'(4 * m_wr));
    chk("wr_count", 32'(wr_count_o), 32'(m_wr));
    chk("done", 32'(done_o), 32'(m_wr == MAXW));
    push = op_valid_i && m_rdy;
    pop = m_we && imem_ready_i;
    w = ref_enc(op_kind_i, rs_i, rt_i, rd_i, funct_i, imm_i, target_i);
    @(posedge clk_i);
    if (clr) begin
      q.delete();
      m_acc = 0;
      m_wr = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        m_wr++;
      end
      if (push) begin
        q.push_back(w);
        m_acc++;
      end
    end
    @(negedge clk_i);
  endtask
  task automatic rand_fields();
    op_kind_i = 3'($urandom);
    rs_i = 5'($urandom);
    rt_i = 5'($urandom);
    rd_i = 5'($urandom);
    funct_i = 6'($urandom);
    imm_i = 16'($urandom);
    target_i = 26'($urandom);
  endtask
  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    step();
    rst_i = 0;
    imem_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      rs_i = 1;
      rt_i = 2;
      case (i)
        0: begin op_kind_i = 4; imm_i = 5; end
        1: begin op_kind_i = 1; imm_i = 4; end
        2: begin op_kind_i = 0; rd_i = 3; funct_i = 6'h20; end
        3: begin op_kind_i = 3; imm_i = 16'hFFFF; end
        default: begin op_kind_i = 6; target_i = 26'h10; end
      endcase
      op_valid_i = 1;
      step();
      op_valid_i = 0;
      #1;
      chk("enc_golden", imem_data_o, golden[i]);
      chk("addr_golden", imem_addr_o, BASE + 32'(4 * i));
      step();
    end
    flush_i = 1;
    step();
    flush_i = 0;
    imem_ready_i = 0;
    op_valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      step();
    end
    #1;
    chk("bp_ready_low", 32'(op_ready_o), 32'h0);
    chk("bp_we_held", 32'(imem_we_o), 32'h1);
    op_valid_i = 0;
    imem_ready_i = 1;
    repeat (6) step();
    flush_i = 1;
    step();
    flush_i = 0;
    op_valid_i = 1;
    for (int i = 0; i < 12; i++) begin
      rand_fields();
      step();
    end
    #1;
    chk("max_done", 32'(done_o), 32'h1);
    chk("max_count", 32'(wr_count_o), 32'(MAXW));
    chk("max_refused", 32'(op_ready_o), 32'h0);
    flush_i = 1;
    step();
    flush_i = 0;
    imem_ready_i = 0;
    repeat (2) begin
      rand_fields();
      step();
    end
    op_valid_i = 0;
    flush_i = 1;
    step();
    flush_i = 0;
    #1;
    chk("flush_we", 32'(imem_we_o), 32'h0);
    chk("flush_count", 32'(wr_count_o), 32'h0);
    imem_ready_i = 1;
    op_valid_i = 1;
    rand_fields();
    step();
    op_valid_i = 0;
    #1;
    chk("flush_addr", imem_addr_o, BASE);
    step();
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      op_valid_i = 1'($urandom);
      imem_ready_i = ($urandom % 3) != 0;
      flush_i = ($urandom % 25) == 0;
      rst_i = ($urandom % 60) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
